// File: rtl/accum_arb_pkg.sv
// Shared types and widths for the accumulator arbiter: FSM state enum,
// default parameter values and the requester-id width helper.
package accum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EN   = 2'd1,
    DROP = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ACCUM_WIDTH    = 256;
  localparam int DEF_ADD_WIDTH      = 128;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_arbiter_if.sv
// Bundle of client request/response and accumulator-side signals of accum_arbiter.
// master = arbiter side, slave = clients plus accumulator instance.
interface accum_arbiter_if #(
  parameter int NUM_REQ     = accum_arb_pkg::DEF_NUM_REQ,
  parameter int ACCUM_WIDTH = accum_arb_pkg::DEF_ACCUM_WIDTH,
  parameter int ADD_WIDTH   = accum_arb_pkg::DEF_ADD_WIDTH
);
  localparam int IDW = accum_arb_pkg::id_width(NUM_REQ);

  // req_ready is a one-cycle accept: the addend is captured in the cycle
  // where req_valid[i] and req_ready[i] are both high; acc_en/acc_done run
  // a four-phase handshake (en up, done up, en down, done down).
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADD_WIDTH-1:0] req_add;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         rsp_valid;
  logic [IDW-1:0]               rsp_id;
  logic [ACCUM_WIDTH-1:0]       rsp_accum;
  logic                         rsp_err;
  logic                         busy;
  logic                         acc_en;
  logic [ADD_WIDTH-1:0]         acc_add;
  logic [ACCUM_WIDTH-1:0]       acc_accum;
  logic                         acc_done;
  accum_arb_pkg::state_t        state;

  modport master (
    input  req_valid, req_add, acc_accum, acc_done,
    output req_ready, rsp_valid, rsp_id, rsp_accum, rsp_err, busy,
           acc_en, acc_add, state
  );

  modport slave (
    output req_valid, req_add, acc_accum, acc_done,
    input  req_ready, rsp_valid, rsp_id, rsp_accum, rsp_err, busy,
           acc_en, acc_add, state
  );

endinterface

// File: rtl/accum_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module accum_rr_pick
  import accum_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req_valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin arbiter sharing one en/done accumulator among NUM_REQ clients.
// Optional handshake watchdog: define ACCUM_ARB_TIMEOUT_EN.
module accum_arbiter
  import accum_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int ADD_WIDTH   = DEF_ADD_WIDTH
`ifdef ACCUM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input logic             clk,
  input logic             reset,
  accum_arbiter_if.master bus
);

  localparam int IDW = id_width(NUM_REQ);

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
  logic [ADD_WIDTH-1:0]   add_q, add_d;
  logic [ACCUM_WIDTH-1:0] accum_q, accum_d, rsp_accum_q, rsp_accum_d;
  logic                   rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
  logic                   acc_en_q, acc_en_d, busy_q, busy_d;
  logic [NUM_REQ-1:0]     req_ready, pick_grant;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_any, timeout, timed_out;
  logic [ADD_WIDTH-1:0]   add_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_add
    assign add_arr[i] = bus.req_add[i*ADD_WIDTH +: ADD_WIDTH];
  end

  accum_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

`ifdef ACCUM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // One counter spans EN and DROP; it restarts only when a new handshake begins.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == EN)        cnt_d = '0;
    else if (state_q == EN || state_q == DROP)   cnt_d = cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_d       = add_q;
    id_d        = id_q;
    accum_d     = accum_q;
    rsp_id_d    = rsp_id_q;
    rsp_accum_d = rsp_accum_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    timed_out   = 1'b0;
    case (state_q)
      IDLE: begin
        // A done level left over from an earlier transaction blocks new grants.
        if (pick_any && !bus.acc_done) begin
          req_ready = pick_grant;
          add_d     = add_arr[pick_idx];
          id_d      = pick_idx;
          ptr_d     = pick_idx;
          state_d   = EN;
        end
      end
      EN: begin
        if (bus.acc_done) begin
          accum_d = bus.acc_accum;
          state_d = DROP;
        end else if (timeout) begin
          timed_out = 1'b1;
          state_d   = RESP;
        end
      end
      DROP: begin
        if (!bus.acc_done) begin
          state_d = RESP;
        end else if (timeout) begin
          timed_out = 1'b1;
          state_d   = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != RESP && state_d == RESP) begin
      rsp_id_d    = id_q;
      rsp_accum_d = timed_out ? '0 : accum_q;
      rsp_err_d   = timed_out;
    end
    acc_en_d    = (state_d == EN);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NUM_REQ - 1);
      add_q       <= '0;
      id_q        <= '0;
      accum_q     <= '0;
      rsp_id_q    <= '0;
      rsp_accum_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      acc_en_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ACCUM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_q       <= add_d;
      id_q        <= id_d;
      accum_q     <= accum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_accum_q <= rsp_accum_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      acc_en_q    <= acc_en_d;
      busy_q      <= busy_d;
`ifdef ACCUM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_accum = rsp_accum_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.acc_add   = add_q;
  assign bus.state     = state_q;

endmodule
